// File: rtl/csr_nfa_traversal.sv
// Dual-stream CSR NFA walker: scans active states, reports accepting ones and follows edges.
// Latency: 3 + indices scanned + per active row (2 + 2*edge_words) cycles per character pair.
// Backpressure: none; the next character pair is requested only after the current one commits.
module csr_nfa_traversal #(
  parameter int size_range = 9514
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [23:0]  size,
  output logic [16:0]  rd_address,
  input  logic [511:0] rd_bus,
  output logic         input_char_flag,
  input  logic [7:0]   input_char,
  input  logic [7:0]   input_char_2,
  output logic [19:0]  i,
  output logic         accepting_match_flag,
  output logic         accepting_match_flag_2
);

  localparam int IW = $clog2(size_range + 1);
  localparam logic [size_range-1:0] start_set = {{(size_range-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, SCAN, ROW_RD, ROW_CHK, EDGE_RD, EDGE_CHK, COMMIT
  } state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         eff_size, scan_idx;
  logic [IW:0]           idx_inc;
  logic                  idx_last, row_live, more_words;
  logic [7:0]            char_1, char_2;
  logic [9:0]            remaining;
  logic [size_range-1:0] act_1, act_2, nxt_1, nxt_2;
  logic [19:0]           slot_dest [16];
  logic [15:0]           hit_1, hit_2;
  logic                  unused_bits;

  assign eff_size        = (size > 24'(size_range)) ? IW'(size_range) : size[IW-1:0];
  assign idx_inc         = {1'b0, scan_idx} + (IW+1)'(1);
  assign idx_last        = idx_inc >= {1'b0, eff_size};
  assign row_live        = (scan_idx < eff_size) && (act_1[scan_idx] || act_2[scan_idx]);
  assign more_words      = remaining > 10'd16;
  assign input_char_flag = (state == FETCH);

  // Decode all 16 slots of the current edge word in parallel.
  always_comb begin
    hit_1       = '0;
    hit_2       = '0;
    unused_bits = 1'b0;
    for (int k = 0; k < 16; k++) begin
      slot_dest[k] = rd_bus[32*k+8 +: 20];
      unused_bits  = unused_bits ^ (^rd_bus[32*k+28 +: 3]);
      if (rd_bus[32*k+31] && (10'(k) < remaining) && (slot_dest[k] < 20'(eff_size))) begin
        hit_1[k] = (rd_bus[32*k +: 8] == char_1) && act_1[scan_idx];
        hit_2[k] = (rd_bus[32*k +: 8] == char_2) && act_2[scan_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = FETCH;
      FETCH:    state_nxt = LATCH;
      LATCH:    state_nxt = (eff_size == '0) ? COMMIT : SCAN;
      SCAN: begin
        if (scan_idx >= eff_size) state_nxt = COMMIT;
        else if (row_live)        state_nxt = ROW_RD;
        else if (idx_last)        state_nxt = COMMIT;
      end
      ROW_RD:   state_nxt = ROW_CHK;
      ROW_CHK: begin
        if (rd_bus[26:17] != 10'd0) state_nxt = EDGE_RD;
        else if (idx_last)          state_nxt = COMMIT;
        else                        state_nxt = SCAN;
      end
      EDGE_RD:  state_nxt = EDGE_CHK;
      EDGE_CHK: begin
        if (more_words)    state_nxt = EDGE_RD;
        else if (idx_last) state_nxt = COMMIT;
        else               state_nxt = SCAN;
      end
      COMMIT:   state_nxt = FETCH;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_address             <= '0;
      i                      <= '0;
      accepting_match_flag   <= 1'b0;
      accepting_match_flag_2 <= 1'b0;
      scan_idx               <= '0;
      char_1                 <= '0;
      char_2                 <= '0;
      remaining              <= '0;
      act_1                  <= start_set;
      act_2                  <= start_set;
      nxt_1                  <= '0;
      nxt_2                  <= '0;
    end else begin
      accepting_match_flag   <= 1'b0;
      accepting_match_flag_2 <= 1'b0;

      if (state == LATCH) begin
        char_1   <= input_char;
        char_2   <= input_char_2;
        scan_idx <= '0;
      end else if (state_nxt == SCAN) begin
        scan_idx <= idx_inc[IW-1:0];
      end

      if (state_nxt == ROW_RD)
        rd_address <= {{(17-IW){1'b0}}, scan_idx};
      else if (state_nxt == EDGE_RD)
        rd_address <= (state == ROW_CHK) ? rd_bus[16:0] : rd_address + 17'd1;

      if (state == ROW_CHK) begin
        i                      <= {{(20-IW){1'b0}}, scan_idx};
        accepting_match_flag   <= act_1[scan_idx] & rd_bus[27];
        accepting_match_flag_2 <= act_2[scan_idx] & rd_bus[27];
        remaining              <= rd_bus[26:17];
      end

      if (state == EDGE_CHK) begin
        if (more_words) remaining <= remaining - 10'd16;
        for (int k = 0; k < 16; k++) begin
          if (hit_1[k]) nxt_1[slot_dest[k][IW-1:0]] <= 1'b1;
          if (hit_2[k]) nxt_2[slot_dest[k][IW-1:0]] <= 1'b1;
        end
      end

      // State 0 is always re-armed so a match can start at any character.
      if (state == COMMIT) begin
        act_1 <= nxt_1 | start_set;
        act_2 <= nxt_2 | start_set;
        nxt_1 <= '0;
        nxt_2 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_csr_nfa_traversal.sv
// Randomized and directed bench for csr_nfa_traversal against a set-based NFA model.
module tb_csr_nfa_traversal;

  logic         tb_clk = 1'b0;
  logic         reset;
  logic [23:0]  size;
  logic [16:0]  rd_address;
  logic [511:0] rd_bus;
  logic         input_char_flag;
  logic [7:0]   input_char, input_char_2;
  logic [19:0]  i;
  logic         accepting_match_flag, accepting_match_flag_2;

  always #5 tb_clk = ~tb_clk;

  csr_nfa_traversal dut (
    .clk(tb_clk), .reset(reset), .size(size), .rd_address(rd_address), .rd_bus(rd_bus),
    .input_char_flag(input_char_flag), .input_char(input_char), .input_char_2(input_char_2),
    .i(i), .accepting_match_flag(accepting_match_flag),
    .accepting_match_flag_2(accepting_match_flag_2)
  );

  logic [511:0] mem [64];
  always @(posedge tb_clk) rd_bus <= mem[rd_address[5:0]];

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  int          fq[$];
  logic [21:0] obs[$];
  always @(negedge tb_clk) begin
    if (input_char_flag) fq.push_back(cyc);
    if (accepting_match_flag || accepting_match_flag_2)
      obs.push_back({i, accepting_match_flag, accepting_match_flag_2});
  end

  int total = 0, bad = 0;
  int fq_base, ob_base, rel;
  bit zerr;

  int       n_st;
  bit       acc [16];
  int       cnt [16];
  bit [7:0] lbl [16][20];
  int       dst [16][20];
  bit       vld [16][20];
  bit [7:0] c1q[$], c2q[$];
  logic [21:0] exp_ev[$];
  int          exp_lat[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_graph();
    n_st = 0;
    for (int s = 0; s < 16; s++) begin
      acc[s] = 0;
      cnt[s] = 0;
      for (int j = 0; j < 20; j++) begin
        lbl[s][j] = 8'h00;
        dst[s][j] = 0;
        vld[s][j] = 0;
      end
    end
  endtask

  task automatic build_mem();
    logic [511:0] ew [2];
    int base;
    for (int a = 0; a < 64; a++) mem[a] = '0;
    for (int s = 0; s < n_st; s++) begin
      base   = 16 + 3 * s;
      mem[s] = {484'd0, acc[s], 10'(cnt[s]), 17'(base)};
      for (int w = 0; w < 2; w++)
        for (int q = 0; q < 16; q++) ew[w][32*q +: 32] = $urandom;
      for (int j = 0; j < cnt[s]; j++)
        ew[j/16][32*(j%16) +: 32] = {vld[s][j], 3'b000, 20'(dst[s][j]), lbl[s][j]};
      mem[base]     = ew[0];
      mem[base + 1] = ew[1];
    end
  endtask

  // Reference: active sets as plain arrays, one character pair at a time.
  task automatic model(input int nch);
    bit a1 [16], a2 [16], n1 [16], n2 [16];
    int rows;
    bit f1, f2;
    exp_ev.delete();
    exp_lat.delete();
    for (int s = 0; s < 16; s++) begin a1[s] = (s == 0); a2[s] = (s == 0); end
    for (int k = 0; k < nch; k++) begin
      for (int s = 0; s < 16; s++) begin n1[s] = 0; n2[s] = 0; end
      rows = 0;
      for (int s = 0; s < n_st; s++) begin
        if (a1[s] || a2[s]) begin
          rows += 2 + 2 * ((cnt[s] + 15) / 16);
          f1 = a1[s] && acc[s];
          f2 = a2[s] && acc[s];
          if (f1 || f2) exp_ev.push_back({20'(s), f1, f2});
          for (int j = 0; j < cnt[s]; j++) begin
            if (vld[s][j] && dst[s][j] < n_st) begin
              if (lbl[s][j] == c1q[k] && a1[s]) n1[dst[s][j]] = 1;
              if (lbl[s][j] == c2q[k] && a2[s]) n2[dst[s][j]] = 1;
            end
          end
        end
      end
      exp_lat.push_back(3 + n_st + rows);
      for (int s = 0; s < 16; s++) begin a1[s] = n1[s] || (s == 0); a2[s] = n2[s] || (s == 0); end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_async_addr", 64'(rd_address), 0);
    repeat (3) @(negedge tb_clk);
    #1;
    chk("rst_outputs", 64'({rd_address, input_char_flag, i, accepting_match_flag,
                            accepting_match_flag_2}), 0);
    fq_base = fq.size();
    ob_base = obs.size();
    zerr    = 0;
    reset   = 1'b1;
    rel     = cyc;
  endtask

  task automatic wait_req(input int need, output bit ok);
    int t = 0;
    while (fq.size() - fq_base < need && t < 3000) begin
      @(negedge tb_clk);
      #1;
      t++;
      if (rd_address != 17'd0) zerr = 1;
    end
    ok = (fq.size() - fq_base >= need);
    if (!ok) chk("req_timeout", 64'(fq.size() - fq_base), 64'(need));
  endtask

  task automatic stream(input int nch);
    bit ok;
    int d, nobs;
    model(nch);
    for (int k = 0; k < nch; k++) begin
      wait_req(k + 1, ok);
      if (!ok) return;
      input_char   = c1q[k];
      input_char_2 = c2q[k];
    end
    wait_req(nch + 1, ok);
    if (!ok) return;
    d = fq[fq_base] - rel;
    chk("first_req_within_2", 64'((d >= 1 && d <= 2) ? 1 : 0), 1);
    for (int k = 0; k < nch; k++)
      chk("req_period", 64'(fq[fq_base+k+1] - fq[fq_base+k]), 64'(exp_lat[k]));
    nobs = obs.size() - ob_base;
    chk("event_count", 64'(nobs), 64'(exp_ev.size()));
    for (int e = 0; e < nobs && e < exp_ev.size(); e++)
      chk("event_i_f1_f2", 64'(obs[ob_base+e]), 64'(exp_ev[e]));
    if (n_st == 0) chk("rd_addr_held_zero", 64'(zerr), 0);
  endtask

  initial begin
    bit ok;
    reset        = 1'b0;
    size         = '0;
    input_char   = '0;
    input_char_2 = '0;
    for (int a = 0; a < 64; a++) mem[a] = '0;
    repeat (2) @(negedge tb_clk);

    // Single edge, lo then hi reach the accepting state on different characters.
    clear_graph();
    n_st = 2; cnt[0] = 1; vld[0][0] = 1; dst[0][0] = 1; lbl[0][0] = 8'h61; acc[1] = 1;
    build_mem();
    size = 24'd2;
    c1q = {8'h61, 8'h62, 8'h00};
    c2q = {8'h78, 8'h61, 8'h00};
    do_reset();
    stream(3);

    // Both streams match together.
    c1q = {8'h61, 8'h00};
    c2q = {8'h61, 8'h00};
    @(negedge tb_clk);
    do_reset();
    stream(2);

    // 17 edges: only slot 16 matches; invalid and past-count slots carry the label too.
    clear_graph();
    n_st = 2; cnt[0] = 17; acc[1] = 1;
    for (int j = 0; j < 16; j++) begin vld[0][j] = 1; dst[0][j] = 1; lbl[0][j] = 8'h70 + 8'(j); end
    vld[0][3] = 0; lbl[0][3] = 8'h61;
    vld[0][16] = 1; dst[0][16] = 1; lbl[0][16] = 8'h61;
    build_mem();
    mem[17][32*1 +: 32] = {1'b1, 3'b000, 20'd1, 8'h61};
    size = 24'd2;
    c1q = {8'h61, 8'h00};
    c2q = {8'h62, 8'h00};
    @(negedge tb_clk);
    do_reset();
    stream(2);

    // Empty automaton.
    clear_graph();
    build_mem();
    size = 24'd0;
    c1q = {8'h61, 8'h61, 8'h61};
    c2q = {8'h61, 8'h61, 8'h61};
    @(negedge tb_clk);
    do_reset();
    stream(3);

    // Reset during the second edge word, after the first word already set a next-state bit.
    clear_graph();
    n_st = 2; cnt[0] = 17; acc[1] = 1;
    vld[0][0] = 1; dst[0][0] = 1; lbl[0][0] = 8'h61;
    vld[0][16] = 1; dst[0][16] = 1; lbl[0][16] = 8'h62;
    build_mem();
    size = 24'd2;
    @(negedge tb_clk);
    do_reset();
    wait_req(1, ok);
    input_char   = 8'h61;
    input_char_2 = 8'h61;
    repeat (8) @(negedge tb_clk);
    #1;
    c1q = {8'h63, 8'h00};
    c2q = {8'h63, 8'h00};
    do_reset();
    stream(2);

    // Random automata and character streams.
    for (int r = 0; r < 25; r++) begin
      clear_graph();
      n_st = $urandom_range(1, 12);
      for (int s = 0; s < n_st; s++) begin
        acc[s] = ($urandom % 3) == 0;
        case ($urandom % 7)
          0: cnt[s] = 0;
          1: cnt[s] = 16;
          2: cnt[s] = 17;
          3: cnt[s] = 20;
          default: cnt[s] = $urandom_range(1, 4);
        endcase
        for (int j = 0; j < cnt[s]; j++) begin
          vld[s][j] = ($urandom % 8) != 0;
          dst[s][j] = $urandom_range(0, n_st + 2);
          lbl[s][j] = 8'($urandom_range(97, 99));
        end
      end
      build_mem();
      size = 24'(n_st);
      c1q.delete();
      c2q.delete();
      for (int k = 0; k < 5; k++) begin
        c1q.push_back(8'($urandom_range(97, 99)));
        c2q.push_back(8'($urandom_range(97, 99)));
      end
      @(negedge tb_clk);
      do_reset();
      stream(5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
